// File: rtl/fft_out_reorder_if.sv
// Stream bundle for fft_out_reorder: bit-reversed lane pairs in, natural-order samples out.
// Handshake: a pair is consumed on every cycle in_valid is high (no backpressure upstream);
// an output sample transfers on a rising edge where out_valid && out_ready, and while
// out_valid is high without out_ready the sample fields hold stable.
interface fft_out_reorder_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_start;
    logic signed [DATA_W-1:0] in_re0;
    logic signed [DATA_W-1:0] in_im0;
    logic signed [DATA_W-1:0] in_re1;
    logic signed [DATA_W-1:0] in_im1;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic [4:0]               out_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_start, in_re0, in_im0, in_re1, in_im1, out_ready,
        input  out_valid, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_start, in_re0, in_im0, in_re1, in_im1, out_ready,
        output out_valid, out_re, out_im, out_idx, out_last
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Reorders 32-point MDC FFT lane pairs into natural order through ping/pong banks.
// Define DROP_CNT_EN to add the saturating 8-bit dropped-frame counter output drop_cnt.
module fft_out_reorder #(
    parameter int DATA_W = 16,
    parameter int N      = 32
) (
    input  logic             clk,
    input  logic             rst,
    fft_out_reorder_if.slave bus,
    output logic             overflow,
`ifdef DROP_CNT_EN
    output logic [7:0]       drop_cnt,
`endif
    output logic             dbg_state
);
    localparam int IDX_W  = $clog2(N);
    localparam int PAIR_W = IDX_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    logic [DATA_W-1:0] mem_re [2][N];
    logic [DATA_W-1:0] mem_im [2][N];

    logic [1:0]        full_q;
    logic              wr_bank;
    logic              rd_bank;
    logic [PAIR_W-1:0] pair_cnt;
    logic              wr_active;
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] re_q, im_q;
    logic              valid_q, last_q;

    logic              start_hit, drop, wr_en, wr_done;
    logic [PAIR_W-1:0] wr_k;
    logic [IDX_W-1:0]  wr_addr0, wr_addr1;
    logic [1:0]        set_mask, clr_mask;

    // Writer: pair k scatters to bitrev(k) and bitrev(k)|1; a full target bank drops the frame.
    always_comb begin
        start_hit = bus.in_valid && bus.in_start;
        drop      = start_hit && full_q[wr_bank];
        wr_en     = (start_hit && !full_q[wr_bank]) ||
                    (bus.in_valid && !bus.in_start && wr_active);
        wr_k      = start_hit ? '0 : pair_cnt;
        wr_done   = wr_en && (wr_k == '1);
        wr_addr0  = '0;
        for (int b = 0; b < PAIR_W; b++) begin
            wr_addr0[IDX_W-1-b] = wr_k[b];
        end
        wr_addr1  = {wr_addr0[IDX_W-1:1], 1'b1};
        set_mask  = {wr_done && wr_bank, wr_done && !wr_bank};
    end

    logic             load, release_bank, rd_sel;
    logic [IDX_W-1:0] rd_addr;

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        release_bank = 1'b0;
        rd_sel       = rd_bank;
        rd_addr      = idx_q + IDX_W'(1);
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank]) begin
                    state_d = READ;
                    load    = 1'b1;
                    rd_addr = '0;
                end
            end
            READ: begin
                if (valid_q && bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        release_bank = 1'b1;
                        rd_addr      = '0;
                        // Chain straight into the other bank when it already holds a frame.
                        if (full_q[~rd_bank]) begin
                            load   = 1'b1;
                            rd_sel = ~rd_bank;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        clr_mask = {release_bank && rd_bank, release_bank && !rd_bank};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_bank][wr_addr0] <= bus.in_re0;
            mem_im[wr_bank][wr_addr0] <= bus.in_im0;
            mem_re[wr_bank][wr_addr1] <= bus.in_re1;
            mem_im[wr_bank][wr_addr1] <= bus.in_im1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            pair_cnt  <= '0;
            wr_active <= 1'b0;
            state_q   <= IDLE;
            idx_q     <= '0;
            re_q      <= '0;
            im_q      <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q  <= state_d;
            overflow <= drop;
            full_q   <= (full_q | set_mask) & ~clr_mask;
            if (drop) begin
                wr_active <= 1'b0;
                pair_cnt  <= '0;
            end else if (wr_en) begin
                wr_active <= !wr_done;
                pair_cnt  <= wr_k + PAIR_W'(1);
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (release_bank) rd_bank <= ~rd_bank;
            if (load) begin
                re_q   <= mem_re[rd_sel][rd_addr];
                im_q   <= mem_im[rd_sel][rd_addr];
                idx_q  <= rd_addr;
                last_q <= (rd_addr == LAST_IDX);
            end else if (state_d == IDLE) begin
                last_q <= 1'b0;
            end
            valid_q <= (state_d == READ);
        end
    end

`ifdef DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (overflow && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_re    = re_q;
    assign bus.out_im    = im_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign dbg_state     = (state_q == READ);
endmodule
